// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if
// Bundles the two handshakes of the fetch/decode queue.
//   in_*  : fetch-group producer (IF stage) -> queue
//   out_* : queue -> consumer (ID stage)
// Modports:
//   slave  : the queue itself (accepts in_*, produces out_*)
//   master : the environment (drives in_* and out_ready)
interface fetch_decode_queue_if #(
    parameter int ISSUE_W = 2,
    parameter int DATA_W  = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_pc;
    logic [ISSUE_W*DATA_W-1:0] in_inst;
    logic [ISSUE_W-1:0]        in_mask;

    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_pc;
    logic [ISSUE_W*DATA_W-1:0] out_inst;
    logic [ISSUE_W-1:0]        out_mask;

    modport slave (
        input  in_valid, in_pc, in_inst, in_mask, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_mask
    );

    modport master (
        output in_valid, in_pc, in_inst, in_mask, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_mask
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
// Circular queue of fetch groups between the IF and ID stages. Each entry holds
// the group PC, ISSUE_W instruction words and a per-slot enable mask.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous active-high reset, empties the queue
//   flush : synchronous discard of all held groups (beats push and pop)
//   count : number of groups currently held
//   bus   : fetch_decode_queue_if.slave (in_* push side, out_* pop side)
// Groups that arrive with an all-zero mask are accepted and silently dropped.
// Head outputs read straight from the storage array and are forced to zero
// whenever the queue is empty, so stale entries never leak out.
module fetch_decode_queue #(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    fetch_decode_queue_if.slave        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    // Entry storage: no reset, contents are only visible while count != 0.
    logic [31:0]               pc_mem   [DEPTH];
    logic [ISSUE_W*DATA_W-1:0] inst_mem [DEPTH];
    logic [ISSUE_W-1:0]        mask_mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Ready/valid depend only on registered occupancy: no path from out_ready.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign count         = count_reg;

    assign push = bus.in_valid && !full && (|bus.in_mask) && !flush;
    assign pop  = !empty && bus.out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so overflow is the wrap.
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_reg]   <= bus.in_pc;
            inst_mem[tail_reg] <= bus.in_inst;
            mask_mem[tail_reg] <= bus.in_mask;
        end
    end

    assign bus.out_pc = bus.out_valid ? pc_mem[head_reg] : 32'h0;

    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            assign bus.out_inst[gi*DATA_W +: DATA_W] =
                bus.out_valid ? inst_mem[head_reg][gi*DATA_W +: DATA_W] : '0;
            assign bus.out_mask[gi] =
                bus.out_valid ? mask_mem[head_reg][gi] : 1'b0;
        end
    endgenerate
endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 Parameter ISSUE_W, default 2, meaning instruction slots per fetch group (1..4).
REQ-002 Parameter DEPTH, default 4, meaning fetch-group entries held (power of two, 2..16).
REQ-003 Parameter DATA_W, default 32, meaning instruction word width.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held groups.
REQ-007 in_valid  input  1  IF presents a fetch group.
REQ-008 in_ready  output  1  queue can accept a group this cycle.
REQ-009 in_pc  input  32  PC of slot 0 of the group.
REQ-010 in_inst  input  ISSUE_W*DATA_W  instructions; slot k at bits [k*DATA_W +: DATA_W].
REQ-011 in_mask  input  ISSUE_W  per-slot enable; bit k qualifies slot k.
REQ-012 out_valid  output  1  head group available to ID.
REQ-013 out_ready  input  1  ID consumes head group this cycle.
REQ-014 out_pc  output  32  PC of head group.
REQ-015 out_inst  output  ISSUE_W*DATA_W  head group instructions, same slot packing.
REQ-016 out_mask  output  ISSUE_W  head group slot enables.
REQ-017 count  output  $clog2(DEPTH)+1  number of groups held.

Function
REQ-018 Push occurs when in_valid & in_ready & (in_mask != 0) & !flush; pc, inst, mask stored at tail.
REQ-019 A group with in_valid=1 and in_mask=0 is dropped: not stored, count unchanged, treated as accepted.
REQ-020 Pop occurs when out_valid & out_ready & !flush; head advances by one.
REQ-021 in_ready = (count != DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-022 out_valid = (count != 0); out_pc/out_inst/out_mask shall be all-zero whenever out_valid=0.
REQ-023 Latency: group pushed in cycle N appears on outputs (if queue was empty) from cycle N+1; no same-cycle bypass.
REQ-024 Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged, order preserved.
REQ-025 Full (count=DEPTH): in_ready=0, no push even if pop occurs that cycle; pop still allowed.
REQ-026 Empty (count=0): out_ready ignored, no pop, count does not underflow.
REQ-027 Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; FIFO order preserved across wrap.
REQ-028 flush has priority over push and pop: next cycle count=0, pointers=0, out_valid=0, outputs zero; input group in flush cycle is discarded.
REQ-029 Outputs held stable while out_valid=1 and out_ready=0.
REQ-030 count updates on the same edge as the push/pop/flush that changes it.

Reset
REQ-031 rst=1 shall immediately (without clock) force count=0, head=tail=0, out_valid=0, out_pc/out_inst/out_mask=0, in_ready=1.
REQ-032 Stored entry contents need not be cleared by reset; they shall never be visible on outputs while out_valid=0.
REQ-033 rst asserted mid-operation (any count, any pending push/pop) shall discard all groups; first push after rst deassertion lands at index 0.

Verification
REQ-034 Reset, then push pc=0x100, inst={0x2,0x1}, mask=2'b11 -> next cycle out_valid=1, out_pc=0x100, out_inst={0x2,0x1}, count=1.
REQ-035 With out_ready=0 push 4 groups (pc 0x0,0x8,0x10,0x18) -> count=4, in_ready=0; a 5th push with pop same cycle -> 5th rejected, count=3, out_pc=0x8.
REQ-036 Push in_mask=2'b00 with in_valid=1 -> count unchanged, out_valid unchanged.
REQ-037 Continuous push and pop for 10 groups (pc 0x0..0x48 step 8), DEPTH=4 -> outputs in exact order, pointers wrap twice, count stays 1.
REQ-038 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pc=0, in_ready=1.
REQ-039 count=2, assert rst between clock edges -> count=0, out_valid=0 before next edge; push after release appears at out_pc of that group.
